// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Start/busy/done handshake; the done cycle can accept the next operation.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             s_bit,
  output logic             c_bit
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             cy;
  logic [CW-1:0]    cnt;

  // Shared full-adder cell, gated so it reads as zero outside RUN
  always_comb begin
    s_bit = 1'b0;
    c_bit = 1'b0;
    if (state == RUN) begin
      s_bit = ra[0] ^ rb[0] ^ cy;
      c_bit = (ra[0] & rb[0]) | (ra[0] & cy) | (rb[0] & cy);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            cy    <= cin;
            rs    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          rs  <= {s_bit, rs[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          cy  <= c_bit;
          cnt <= cnt + CW'(1);
          // Result is committed on the last-bit edge so sum/cout stay stable meanwhile
          if (cnt == LAST) begin
            sum   <= {s_bit, rs[WIDTH-1:1]};
            cout  <= c_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases plus random operands against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         s_bit;
  logic         c_bit;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .s_bit(s_bit), .c_bit(c_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation; caller is positioned #1 after an edge in IDLE or DONE.
  // hold keeps start high for back-to-back; glitch is the RUN cycle with a stray start (-1 none).
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input bit hold, input int glitch);
    int unsigned total;
    int unsigned lo;
    int unsigned mask;
    a = op_a; b = op_b; cin = op_cin; start = 1'b1;
    total = int'(op_a) + int'(op_b) + int'(op_cin);
    step();
    for (int i = 0; i < W; i++) begin
      mask = (32'd1 << (i + 1)) - 1;
      lo   = (int'(op_a) & mask) + (int'(op_b) & mask) + int'(op_cin);
      check($sformatf("busy_run%0d", i), busy, 1);
      check($sformatf("done_run%0d", i), done, 0);
      check($sformatf("s_bit%0d", i), s_bit, (total >> i) & 1);
      check($sformatf("c_bit%0d", i), c_bit, (lo >> (i + 1)) & 1);
      check($sformatf("sum_hold%0d", i), {cout, sum}, {held_cout, held_sum});
      start = hold || (i == glitch);
      a = (i == glitch) ? 8'hAA : W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      step();
    end
    held_sum  = W'(total);
    held_cout = total[W];
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("sum", sum, held_sum);
    check("cout", cout, held_cout);
    check("s_bit_done", {s_bit, c_bit}, 0);
  endtask

  task automatic expect_idle(input string tag);
    start = 1'b0;
    step();
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", {cout, sum}, 0);
    check("rst_fa", {s_bit, c_bit}, 0);
    rst_n = 1'b1; start = 1'b0;
    step();
    check("idle_busy", busy, 0);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1);
    expect_idle("after_5a");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
    expect_idle("after_ff01");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1);
    expect_idle("after_ffff");
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 3);
    expect_idle("after_glitch");
    expect_idle("still_idle");

    run_op(8'h10, 8'h20, 1'b0, 1'b1, -1);
    run_op(8'h10, 8'h20, 1'b0, 1'b1, -1);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, -1);
    expect_idle("after_b2b");

    for (int n = 0; n < 10; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), -1);
    end
    expect_idle("after_rand");

    // Abort mid-operation
    a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", {cout, sum}, 0);
    check("abort_fa", {s_bit, c_bit}, 0);
    held_sum = '0; held_cout = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      step();
      check($sformatf("post_abort%0d", i), {busy, done}, 0);
    end
    run_op(8'h77, 8'h11, 1'b0, 1'b0, -1);
    expect_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder. It time-multiplexes a single one-bit full-adder cell with a carry flip-flop to add two parallel operands LSB-first, one bit per clock. It sits directly downstream of the one-bit full-adder stage: it feeds that cell one bit pair plus the registered carry each cycle and consumes its sum/carry outputs. It returns the parallel sum and carry-out through a start/busy/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- start  input  1  request a new addition; sampled only in IDLE or DONE.
- a  input  WIDTH  addend A; captured on the accepted start edge.
- b  input  WIDTH  addend B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result register; holds until the next accepted start.
- cout  output  1  carry out of bit WIDTH-1; holds with sum.
- s_bit  output  1  full-adder sum bit of the current RUN cycle; 0 outside RUN.
- c_bit  output  1  full-adder carry bit of the current RUN cycle; 0 outside RUN.

## Operation
- Datapath:
  - Operand shift registers ra, rb (WIDTH bits each).
  - Carry flip-flop cy.
  - Result shift register rs (WIDTH bits).
  - Bit counter cnt, width clog2(WIDTH+1).
- Full-adder cell, combinational on x=ra[0], y=rb[0], z=cy:
  - s_bit = x^y^z
  - c_bit = xy|xz|yz
  - Both are forced to 0 when not in RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load ra=a, rb=b, cy=cin, cnt=0, rs=0; go RUN.
  - start=0 → stay IDLE.
- RUN, every cycle:
  - rs <= {s_bit, rs[WIDTH-1:1]}
  - ra <= ra>>1, rb <= rb>>1 (zero fill)
  - cy <= c_bit
  - cnt <= cnt+1
  - When cnt==WIDTH-1 (last bit): go DONE; sum <= {s_bit, rs[WIDTH-1:1]} and cout <= c_bit on the same edge.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 → load as in IDLE and go RUN (back-to-back).
  - start=0 → go IDLE.
- start during RUN is ignored; no queuing and no error flag.
- a, b and cin are don't-care outside the accepting edge. Changing them during RUN does not affect the result.
- The result is exact modulo 2^WIDTH; {cout,sum} equals a+b+cin.

## Timing
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, s_bit=0, c_bit=0, cnt=0, cy=0, ra=rb=rs=0.
  - Reset overrides start.
- Reset mid-RUN aborts the operation: no done pulse, and sum/cout are cleared to 0.
- Latency, with start accepted at edge k:
  - busy=1 from after edge k through edge k+WIDTH (WIDTH cycles).
  - done=1 and sum/cout valid after edge k+WIDTH.
  - Total start-to-done is WIDTH+1 cycles, counting the start cycle.
- Throughput: back-to-back operations with start held high give one result every WIDTH+1 cycles. The done cycle doubles as the next accept cycle.
- sum/cout change only on the last-bit edge or on reset. They stay stable through RUN of the next operation until its own last-bit edge.
- s_bit/c_bit during RUN cycle i (i=0..WIDTH-1) equal bit i of the sum and the carry out of bit i.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed one cycle → busy high 8 cycles; done pulse on cycle 9; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; c_bit=1 in all 8 RUN cycles.
- a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start a=0x01, b=0x02; at RUN cycle 3 pulse start with a=0xAA and change a/b → start ignored; done once with sum=0x03, cout=0; then IDLE.
- Start held high continuously with a=0x10, b=0x20 → done every 9 cycles with sum=0x30; busy low only in the done cycles.
- Start a=0x77, b=0x11; assert rst_n=0 at RUN cycle 4 → next cycle: IDLE, busy=0, done=0, sum=0, cout=0; no done pulse afterwards without a new start.
